// File: rtl/sm_arb_pkg.sv
// Shared types and constants for the sign-magnitude adder arbiter.
//   state_e : controller FSM states (idle / operands latched / result held)
//   IdW     : width of the requester id carried with each result
package sm_arb_pkg;

    localparam int unsigned IdW = 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StHold = 2'd2
    } state_e;

endpackage

// File: rtl/sm_add_arbiter_if.sv
// Handshake bundle for sm_add_arbiter: two operand request channels and one result channel.
//   req0_* / req1_* : valid, operands a/b (sign-magnitude, N bits), ready
//   res_*           : valid, sum, id, ready, and res_ovf when SM_ARB_OVF_EN is defined
//   modport slave   : arbiter side;  modport master : requester/consumer side
interface sm_add_arbiter_if
    import sm_arb_pkg::*;
#(
    parameter int unsigned N = 4
);
    logic           req0_valid;
    logic [N-1:0]   req0_a;
    logic [N-1:0]   req0_b;
    logic           req0_ready;
    logic           req1_valid;
    logic [N-1:0]   req1_a;
    logic [N-1:0]   req1_b;
    logic           req1_ready;
    logic           res_valid;
    logic [N-1:0]   res_sum;
    logic [IdW-1:0] res_id;
    logic           res_ready;
`ifdef SM_ARB_OVF_EN
    logic           res_ovf;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_sum, res_id, res_ovf
    );
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_sum, res_id, res_ovf
    );
`else
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_sum, res_id
    );
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_sum, res_id
    );
`endif
endinterface

// File: rtl/sign_mag_add.sv
// Combinational sign-magnitude adder, bit N-1 is the sign.
//   a_i, b_i : operands
//   sum_o    : sum; same signs add magnitudes (carry dropped), differing signs subtract
//              the smaller magnitude, sign follows a only when |a| > |b| (so -0 can appear)
module sign_mag_add #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o
);
    logic [N-2:0] mag_a, mag_b, mag;
    logic         sign;

    assign mag_a = a_i[N-2:0];
    assign mag_b = b_i[N-2:0];

    always_comb begin
        mag  = '0;
        sign = 1'b0;
        if (a_i[N-1] == b_i[N-1]) begin
            mag  = mag_a + mag_b;
            sign = a_i[N-1];
        end else if (mag_a > mag_b) begin
            mag  = mag_a - mag_b;
            sign = a_i[N-1];
        end else begin
            mag  = mag_b - mag_a;
            sign = b_i[N-1];
        end
    end

    assign sum_o = {sign, mag};
endmodule

// File: rtl/sm_rr_arbiter.sv
// Two-input round-robin grant logic.
//   clk, reset         : clock, async active-high reset
//   valid0_i, valid1_i : request valids
//   en_i               : grants may be issued (controller idle)
//   accept_i           : a grant was taken this cycle; remember it as last_grant
//   grant_o            : id picked this cycle; gnt0_o / gnt1_o : qualified one-hot grants
module sm_rr_arbiter
    import sm_arb_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           valid0_i,
    input  logic           valid1_i,
    input  logic           en_i,
    input  logic           accept_i,
    output logic [IdW-1:0] grant_o,
    output logic           gnt0_o,
    output logic           gnt1_o
);
    logic [IdW-1:0] last_q;

    always_comb begin
        grant_o = '0;
        if (valid0_i && valid1_i) begin
            grant_o = ~last_q;
        end else if (valid1_i) begin
            grant_o = IdW'(1);
        end
    end

    assign gnt0_o = en_i && valid0_i && (grant_o == IdW'(0));
    assign gnt1_o = en_i && valid1_i && (grant_o == IdW'(1));

    // last_grant starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= IdW'(1);
        end else if (accept_i) begin
            last_q <= grant_o;
        end
    end
endmodule

// File: rtl/sm_add_arbiter.sv
// Shares one sign-magnitude adder between two requesters (round robin).
//   clk, reset : clock, async active-high reset (aborts any in-flight operation)
//   bus        : sm_add_arbiter_if.slave - request channels 0/1 and the result channel
// Flow: IDLE accepts one pair, CALC registers the sum, HOLD presents it until res_ready.
// Optional: define SM_ARB_OVF_EN to add res_ovf (magnitude carry on same-sign add).
module sm_add_arbiter
    import sm_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic            clk,
    input  logic            reset,
    sm_add_arbiter_if.slave bus
);
    state_e         state_q, state_d;
    logic [N-1:0]   a_q, b_q, sum_q, sum_w;
    logic [IdW-1:0] id_q, res_id_q, grant;
    logic           gnt0, gnt1, accept;

    sm_rr_arbiter u_rr (
        .clk      (clk),
        .reset    (reset),
        .valid0_i (bus.req0_valid),
        .valid1_i (bus.req1_valid),
        .en_i     (state_q == StIdle),
        .accept_i (accept),
        .grant_o  (grant),
        .gnt0_o   (gnt0),
        .gnt1_o   (gnt1)
    );

    // grants are already qualified by valid, so either one is an acceptance
    assign accept = gnt0 || gnt1;

    sign_mag_add #(.N(N)) u_add (
        .a_i   (a_q),
        .b_i   (b_q),
        .sum_o (sum_w)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StCalc;
            StCalc:  state_d = StHold;
            StHold:  if (bus.res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            sum_q    <= '0;
            res_id_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q  <= (grant == IdW'(1)) ? bus.req1_a : bus.req0_a;
                b_q  <= (grant == IdW'(1)) ? bus.req1_b : bus.req0_b;
                id_q <= grant;
            end
            if (state_q == StCalc) begin
                sum_q    <= sum_w;
                res_id_q <= id_q;
            end
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.res_valid  = (state_q == StHold);
    assign bus.res_sum    = sum_q;
    assign bus.res_id     = res_id_q;

`ifdef SM_ARB_OVF_EN
    logic [N-1:0] mag_sum;
    logic         ovf_q;

    // carry out of the magnitude field, only meaningful when signs match
    assign mag_sum = {1'b0, a_q[N-2:0]} + {1'b0, b_q[N-2:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (state_q == StCalc) begin
            ovf_q <= (a_q[N-1] == b_q[N-1]) && mag_sum[N-1];
        end
    end

    assign bus.res_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_sm_add_arbiter.sv
// Directed self-checking bench for sm_add_arbiter (N = 4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sm_add_arbiter;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
`ifdef SM_ARB_OVF_EN
    logic last_ovf;
`endif

    always #5 clk = ~clk;

    sm_add_arbiter_if #(.N(N)) bus ();

    sm_add_arbiter #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic clear_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.res_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One complete transaction from IDLE; returns what was observed, leaves FSM in IDLE.
    task automatic run_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                          output logic rdy, output logic vld, output logic [3:0] sum,
                          output logic rid);
        if (id == 1'b0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end
        #1;
        rdy = (id == 1'b0) ? bus.req0_ready : bus.req1_ready;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        vld = bus.res_valid;
        sum = bus.res_sum;
        rid = bus.res_id;
`ifdef SM_ARB_OVF_EN
        last_ovf = bus.res_ovf;
`endif
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.res_valid); end
        checks++; if (bus.res_sum !== 4'b0000) begin errors++; $display("FAIL reset_sum: got %b want 0000", bus.res_sum); end
        checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL reset_id: got %b want 0", bus.res_id); end
        checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {bus.req1_ready, bus.req0_ready}); end
`ifdef SM_ARB_OVF_EN
        checks++; if (bus.res_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.res_ovf); end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie();
        apply_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 4'b0001; bus.req0_b = 4'b0010;
        bus.req1_valid = 1'b1; bus.req1_a = 4'b0001; bus.req1_b = 4'b0001;
        #1;
        checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin errors++; $display("FAIL tie_first_grant: got %b want 01", {bus.req1_ready, bus.req0_ready}); end
        @(negedge clk);
        checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin errors++; $display("FAIL tie_calc_ready: got %b want 00", {bus.req1_ready, bus.req0_ready}); end
        @(negedge clk);
        checks++; if ({bus.res_valid, bus.res_id, bus.res_sum} !== {1'b1, 1'b0, 4'b0011}) begin errors++; $display("FAIL tie_res0: got v%b id%b %b want v1 id0 0011", bus.res_valid, bus.res_id, bus.res_sum); end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin errors++; $display("FAIL tie_second_grant: got %b want 10", {bus.req1_ready, bus.req0_ready}); end
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        checks++; if ({bus.res_valid, bus.res_id, bus.res_sum} !== {1'b1, 1'b1, 4'b0010}) begin errors++; $display("FAIL tie_res1: got v%b id%b %b want v1 id1 0010", bus.res_valid, bus.res_id, bus.res_sum); end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_single();
        logic rdy, vld, rid;
        logic [3:0] sum;
        run_op(1'b0, 4'b0011, 4'b1101, rdy, vld, sum, rid);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", rdy); end
        checks++; if (vld !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", vld); end
        checks++; if (sum !== 4'b1010) begin errors++; $display("FAIL single_sum: got %b want 1010", sum); end
        checks++; if (rid !== 1'b0) begin errors++; $display("FAIL single_id: got %b want 0", rid); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %b want 0", bus.res_valid); end
    endtask

    task automatic test_backpressure();
        bus.req0_valid = 1'b1; bus.req0_a = 4'b0010; bus.req0_b = 4'b0001;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 4'b0111; bus.req1_b = 4'b0111;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.res_valid, bus.res_id, bus.res_sum, bus.req1_ready, bus.req0_ready} !== {1'b1, 1'b0, 4'b0011, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v%b id%b %b rdy%b%b want v1 id0 0011 rdy00", i, bus.res_valid, bus.res_id, bus.res_sum, bus.req1_ready, bus.req0_ready);
            end
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checks++; if ({bus.res_valid, bus.req1_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got v%b rdy1 %b want v0 rdy1 1", bus.res_valid, bus.req1_ready); end
        bus.req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_neg_zero();
        logic rdy, vld, rid;
        logic [3:0] sum;
        run_op(1'b1, 4'b1011, 4'b0011, rdy, vld, sum, rid);
        checks++; if ({rdy, vld, rid, sum} !== {3'b111, 4'b0000}) begin errors++; $display("FAIL negzero_pos: got r%b v%b id%b %b want r1 v1 id1 0000", rdy, vld, rid, sum); end
        run_op(1'b0, 4'b0011, 4'b1011, rdy, vld, sum, rid);
        checks++; if ({rdy, vld, rid, sum} !== {3'b110, 4'b1000}) begin errors++; $display("FAIL negzero_neg: got r%b v%b id%b %b want r1 v1 id0 1000", rdy, vld, rid, sum); end
    endtask

    task automatic test_overflow();
        logic rdy, vld, rid;
        logic [3:0] sum;
        run_op(1'b0, 4'b0101, 4'b0110, rdy, vld, sum, rid);
        checks++; if ({rdy, vld, rid, sum} !== {3'b110, 4'b0011}) begin errors++; $display("FAIL ovf_sum: got r%b v%b id%b %b want r1 v1 id0 0011", rdy, vld, rid, sum); end
`ifdef SM_ARB_OVF_EN
        checks++; if (last_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", last_ovf); end
`endif
        run_op(1'b1, 4'b0010, 4'b0001, rdy, vld, sum, rid);
        checks++; if ({rdy, vld, rid, sum} !== {3'b111, 4'b0011}) begin errors++; $display("FAIL noovf_sum: got r%b v%b id%b %b want r1 v1 id1 0011", rdy, vld, rid, sum); end
`ifdef SM_ARB_OVF_EN
        checks++; if (last_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", last_ovf); end
`endif
    endtask

    // Both requesters always valid, consumer always ready: grants alternate every 3 cycles.
    task automatic test_back_to_back();
        logic exp;
        apply_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 4'b0100; bus.req0_b = 4'b0001;
        bus.req1_valid = 1'b1; bus.req1_a = 4'b1010; bus.req1_b = 4'b1001;
        bus.res_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = i[0];
            #1;
            checks++; if ({bus.req1_ready, bus.req0_ready} !== (exp ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_grant[%0d]: got %b want %b", i, {bus.req1_ready, bus.req0_ready}, (exp ? 2'b10 : 2'b01)); end
            @(negedge clk);
            @(negedge clk);
            checks++; if ({bus.res_valid, bus.res_id, bus.res_sum} !== {1'b1, exp, (exp ? 4'b1011 : 4'b0101)}) begin errors++; $display("FAIL b2b_res[%0d]: got v%b id%b %b want v1 id%b %b", i, bus.res_valid, bus.res_id, bus.res_sum, exp, (exp ? 4'b1011 : 4'b0101)); end
            @(negedge clk);
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_calc();
        bus.req0_valid = 1'b1; bus.req0_a = 4'b0011; bus.req0_b = 4'b0001;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_calc_valid0: got %b want 0", bus.res_valid); end
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_calc_valid1: got %b want 0", bus.res_valid); end
        @(negedge clk);
        checks++; if ({bus.res_valid, bus.res_sum} !== 5'b0_0000) begin errors++; $display("FAIL rst_calc_valid2: got v%b %b want v0 0000", bus.res_valid, bus.res_sum); end
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin errors++; $display("FAIL rst_calc_tie: got %b want 01", {bus.req1_ready, bus.req0_ready}); end
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_backpressure();
        test_neg_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sm_add_arbiter.md
# sm_add_arbiter

Round-robin controller that shares one sign-magnitude adder between two requesters. Each requester presents an operand pair with a valid/ready handshake. The block latches the winning pair and drives the combinational adder. It returns the registered sum, tagged with the requester id, on a valid/ready result port. It sits between switch/button-driven operand sources and the 7-segment display path in the sign-magnitude demo design.

## Interface
- N, default 4: operand and result width; bit N-1 is the sign, bits N-2:0 are the magnitude.
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a, req0_b  in  N each  requester 0 operands, sign-magnitude.
- req0_ready  out  1  requester 0 pair accepted this cycle.
- req1_valid, req1_a, req1_b, req1_ready: same meaning for requester 1.
- res_valid  out  1  result available.
- res_sum  out  N  sign-magnitude sum.
- res_id  out  1  requester that produced res_sum.
- res_ready  in  1  consumer takes the result.
- res_ovf  out  1  magnitude overflow; present only with SM_ARB_OVF_EN.

## Operation
- The FSM has three states:
  - IDLE: waits for a request.
  - CALC: operands are latched; the adder output is registered.
  - HOLD: the result is presented.
- IDLE:
  - grant = round-robin pick among the valid requesters.
  - reqX_ready = (state==IDLE) && grant==X, combinational.
  - Acceptance (valid && ready at the edge) latches a, b and the id, updates last_grant to the id, and moves to CALC.
- CALC: one cycle only. The adder output is captured into res_sum/res_id (and res_ovf), then the FSM moves to HOLD.
- HOLD: res_valid=1. res_sum, res_id and res_ovf stay stable until res_valid && res_ready, then the FSM returns to IDLE.
- Round-robin rules:
  - If only one requester is valid, it is granted.
  - If both are valid, the one not equal to last_grant is granted.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Arithmetic:
  - If the signs are equal: magnitudes are added, the sign is kept, and the sum is truncated to N-1 bits.
  - If the signs differ: the smaller magnitude is subtracted from the larger.
  - The sign is that of a if |a|>|b|, else that of b. Equal magnitudes with differing signs therefore give magnitude 0 with sign of b (negative zero is permitted and is not normalised).
- A requester whose valid drops before it is accepted is simply not granted. Nothing is latched from it.
- res_ready while res_valid=0 is ignored.

## Timing
- Reset values: state=IDLE, req0_ready=req1_ready=0 (no valid), res_valid=0, res_sum=0, res_id=0, res_ovf=0, last_grant=1.
- Asserting reset at any time aborts any in-flight operation immediately. The latched result is discarded and the requester is not re-served.
- Latency: a pair accepted at edge k gives res_valid=1 after edge k+1.
- Result handshake at edge m returns the FSM to IDLE. The earliest next acceptance is edge m+1.
- Peak throughput is one sum per 3 cycles when res_ready is held high.
- At most one reqX_ready is high in any cycle. Both are 0 outside IDLE.
- Back-to-back ties alternate grants 0,1,0,1.

## Configuration
- SM_ARB_OVF_EN defined:
  - Port res_ovf exists.
  - res_ovf=1 when the signs are equal and the magnitude addition carries out of bit N-2.
  - It is registered in CALC alongside res_sum.
- SM_ARB_OVF_EN undefined: there is no res_ovf port and no carry logic. res_sum behaviour is identical.

## Structure
- Package sm_arb_pkg holds the FSM state enum (IDLE, CALC, HOLD) and the requester-id width constant (1).
- Sub-module sm_rr_arbiter: two-input round-robin grant logic holding last_grant. Its inputs are the valids, an enable (state==IDLE) and the accept strobe.
- The sign-magnitude addition reuses the existing sign_mag_add unit (parameter N) instantiated inside. With SM_ARB_OVF_EN, a local carry compare is added beside it.

## Test plan
- Single request: req0 a=0011 (+3), b=1101 (-5) → req0_ready at first cycle. res_valid after 2 edges with res_sum=1010 (-2), res_id=0.
- Tie after reset: both valid, req1 a=0001, b=0001 → req0 granted first, then req1. Results in order id0, then id1 with sum 0010.
- Backpressure: res_ready=0 for 5 cycles in HOLD → res_sum and res_id stable, both reqX_ready=0. Release → IDLE next cycle.
- Negative zero: a=1011 (-3), b=0011 (+3) → res_sum=0000. With a=0011, b=1011 → res_sum=1000.
- Overflow (macro on): a=0101, b=0110 → res_sum=0011, res_ovf=1. With a=0010, b=0001 → res_ovf=0, res_sum=0011.
- Reset mid-CALC: assert reset the cycle after acceptance → res_valid stays 0, state IDLE, last_grant=1. A fresh tie is then granted to requester 0.
